// File: rtl/load_store_unit.sv
// Load/store unit: turns memory-stage strobes into a req/ack bus transaction with
// byte-lane formatting, a datapath stall, and a bounded wait that converts a lost ack into a fault.
module load_store_unit #(
  parameter int unsigned TIMEOUT    = 15,
  parameter logic [31:0] FAULT_DATA = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        ByteOp,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Stall,
  output logic        Fault,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  // state | meaning
  // IDLE  | waiting for MemRead/MemWrite; latches the request and stalls at once
  // REQ   | bus request held with registered address/data until ack or timeout
  // DONE  | one unstalled cycle so the datapath commits; never re-issues

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

  state_t      state;
  state_t      state_next;
  logic [7:0]  wait_cnt;
  logic        is_load;
  logic        byte_op_q;
  logic [1:0]  lane_q;
  logic        access;
  logic        start;
  logic        ack_hit;
  logic        timeout_hit;
  logic [3:0]  be_fmt;
  logic [31:0] wdata_fmt;
  logic [31:0] rdata_fmt;

  assign access      = MemRead | MemWrite;
  assign start       = (state == IDLE) && access;
  assign ack_hit     = (state == REQ) && mem_ack;
  assign timeout_hit = (state == REQ) && !mem_ack && (wait_cnt == LAST_WAIT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (access) state_next = REQ;
      REQ:  if (mem_ack || timeout_hit) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    Stall   = 1'b0;
    mem_req = 1'b0;
    case (state)
      IDLE: Stall = access;
      REQ: begin
        Stall   = 1'b1;
        mem_req = 1'b1;
      end
      DONE: begin
        Stall   = 1'b0;
        mem_req = 1'b0;
      end
      default: begin
        Stall   = 1'b0;
        mem_req = 1'b0;
      end
    endcase
  end

  // A simultaneous read and write is treated as a store.
  always_comb begin
    be_fmt    = 4'b1111;
    wdata_fmt = WriteData;
    if (ByteOp) begin
      be_fmt    = 4'b0001 << Addr[1:0];
      wdata_fmt = {4{WriteData[7:0]}};
    end
  end

  always_comb begin
    rdata_fmt = mem_rdata;
    if (byte_op_q) begin
      case (lane_q)
        2'd0:    rdata_fmt = {24'b0, mem_rdata[7:0]};
        2'd1:    rdata_fmt = {24'b0, mem_rdata[15:8]};
        2'd2:    rdata_fmt = {24'b0, mem_rdata[23:16]};
        default: rdata_fmt = {24'b0, mem_rdata[31:24]};
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_we    <= 1'b0;
      mem_addr  <= 32'b0;
      mem_wdata <= 32'b0;
      mem_be    <= 4'b0;
      is_load   <= 1'b0;
      byte_op_q <= 1'b0;
      lane_q    <= 2'b0;
      wait_cnt  <= 8'b0;
    end else begin
      if (start) begin
        mem_we    <= MemWrite;
        mem_addr  <= {Addr[31:2], 2'b00};
        mem_wdata <= wdata_fmt;
        mem_be    <= be_fmt;
        is_load   <= !MemWrite;
        byte_op_q <= ByteOp;
        lane_q    <= Addr[1:0];
        wait_cnt  <= 8'b0;
      end else if ((state == REQ) && !mem_ack) begin
        wait_cnt <= wait_cnt + 8'd1;
      end
    end
  end

  // Fault is registered on the abort edge so it is high exactly for the DONE cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ReadData <= 32'b0;
      Fault    <= 1'b0;
    end else begin
      Fault <= timeout_hit;
      if (ack_hit && is_load) begin
        ReadData <= rdata_fmt;
      end else if (timeout_hit && is_load) begin
        ReadData <= FAULT_DATA;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: table of accesses through a scoreboard,
// plus hand sequences for reset mid-request and back-to-back held strobes.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemRead, MemWrite, ByteOp;
  logic [31:0] Addr, WriteData;
  logic [31:0] ReadData;
  logic        Stall, Fault;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        rd;
    logic        wr;
    logic        bop;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rdata;
    int          waits;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic        e_we;
    logic [31:0] e_rd;
    int          e_stall;
    int          e_req;
    logic        e_fault;
  } vec_t;

  vec_t vecs[10];
  vec_t exp_q[$];

  load_store_unit #(.TIMEOUT(15), .FAULT_DATA(32'hDEADBEEF)) dut (
    .clk(clk), .reset(reset),
    .MemRead(MemRead), .MemWrite(MemWrite), .ByteOp(ByteOp),
    .Addr(Addr), .WriteData(WriteData),
    .ReadData(ReadData), .Stall(Stall), .Fault(Fault),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    vec_t        e;
    int          stall_cnt = 0;
    int          req_cnt = 0;
    int          fault_cnt = 0;
    bit          done = 1'b0;
    bit          stable = 1'b1;
    logic [31:0] a0, w0;
    logic [3:0]  b0;
    logic        we0;
    MemRead = v.rd; MemWrite = v.wr; ByteOp = v.bop; Addr = v.addr; WriteData = v.wd;
    exp_q.push_back(v);
    for (int c = 0; c < 64 && !done; c++) begin
      #1;
      if (Stall) stall_cnt++;
      if (Fault) fault_cnt++;
      if (mem_req) begin
        req_cnt++;
        if (req_cnt == 1) begin
          a0 = mem_addr; b0 = mem_be; w0 = mem_wdata; we0 = mem_we;
          check({tag, " mem_addr"}, mem_addr, v.e_addr);
          check({tag, " mem_be"}, {28'b0, mem_be}, {28'b0, v.e_be});
          check({tag, " mem_wdata"}, mem_wdata, v.e_wdata);
          check({tag, " mem_we"}, {31'b0, mem_we}, {31'b0, v.e_we});
        end else if (mem_addr !== a0 || mem_be !== b0 || mem_wdata !== w0 || mem_we !== we0) begin
          stable = 1'b0;
        end
        mem_ack   = (req_cnt - 1 == v.waits);
        mem_rdata = mem_ack ? v.rdata : ~v.rdata;
      end else begin
        mem_ack = 1'b0;
        if (req_cnt > 0) begin
          done = 1'b1;
          e = exp_q.pop_front();
          check({tag, " done_stall"}, {31'b0, Stall}, 32'd0);
          check({tag, " done_fault"}, {31'b0, Fault}, {31'b0, e.e_fault});
          check({tag, " ReadData"}, ReadData, e.e_rd);
          MemRead = 1'b0; MemWrite = 1'b0;
        end
      end
      if (!done) @(negedge clk);
    end
    if (!done) begin
      checks++; failures++;
      $display("FAIL %s done_wait actual=no_done required=done", tag);
      MemRead = 1'b0; MemWrite = 1'b0; mem_ack = 1'b0;
      void'(exp_q.pop_front());
    end
    check({tag, " stall_cycles"}, stall_cnt, v.e_stall);
    check({tag, " req_cycles"}, req_cnt, v.e_req);
    check({tag, " fault_cycles"}, fault_cnt, {31'b0, v.e_fault});
    check({tag, " bus_stable"}, {31'b0, stable}, 32'd1);
    @(negedge clk);
  endtask

  initial begin
    vec_t post_st, post_ld;
    bit   ok;
    int   rises, req_hi, done_cnt, last_rise;
    logic prev;

    vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h100, 32'hCAFEF00D, 32'h12345678, 0,
                32'h100, 4'hF, 32'hCAFEF00D, 1'b0, 32'h12345678, 2, 1, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 1'b1, 32'h203, 32'hAABBCCDD, 32'h0, 2,
                32'h200, 4'h8, 32'hDDDDDDDD, 1'b1, 32'h12345678, 4, 3, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 32'h41, 32'h77, 32'h11223344, 1,
                32'h40, 4'h2, 32'h77777777, 1'b0, 32'h33, 3, 2, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 32'h307, 32'h01020304, 32'h0, 0,
                32'h304, 4'hF, 32'h01020304, 1'b1, 32'h33, 2, 1, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 32'h10, 32'h55AA55AA, 32'h99999999, 0,
                32'h10, 4'hF, 32'h55AA55AA, 1'b1, 32'h33, 2, 1, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 32'h80, 32'h0, 32'hFFEEDDCC, 3,
                32'h80, 4'h1, 32'h0, 1'b0, 32'hCC, 5, 4, 1'b0};
    vecs[6] = '{1'b1, 1'b0, 1'b1, 32'h82, 32'h0, 32'hFFEEDDCC, 0,
                32'h80, 4'h4, 32'h0, 1'b0, 32'hEE, 2, 1, 1'b0};
    vecs[7] = '{1'b1, 1'b0, 1'b0, 32'h500, 32'h0, 32'h0, 255,
                32'h500, 4'hF, 32'h0, 1'b0, 32'hDEADBEEF, 16, 15, 1'b1};
    vecs[8] = '{1'b0, 1'b1, 1'b1, 32'h601, 32'h12, 32'h0, 255,
                32'h600, 4'h2, 32'h12121212, 1'b1, 32'hDEADBEEF, 16, 15, 1'b1};
    vecs[9] = '{1'b1, 1'b0, 1'b0, 32'h700, 32'h0, 32'h0BADF00D, 14,
                32'h700, 4'hF, 32'h0, 1'b0, 32'h0BADF00D, 16, 15, 1'b0};
    post_st = '{1'b0, 1'b1, 1'b0, 32'hA10, 32'h1, 32'h0, 0,
                32'hA10, 4'hF, 32'h1, 1'b1, 32'h0, 2, 1, 1'b0};
    post_ld = '{1'b1, 1'b0, 1'b0, 32'hA00, 32'h0, 32'h76543210, 0,
                32'hA00, 4'hF, 32'h0, 1'b0, 32'h76543210, 2, 1, 1'b0};

    reset = 1'b1;
    MemRead = 1'b0; MemWrite = 1'b0; ByteOp = 1'b0;
    Addr = 32'h0; WriteData = 32'h0; mem_rdata = 32'h0; mem_ack = 1'b0;
    @(negedge clk); @(negedge clk);
    check("rst ReadData", ReadData, 32'h0);
    check("rst Fault", {31'b0, Fault}, 32'h0);
    check("rst mem_req", {31'b0, mem_req}, 32'h0);
    check("rst mem_we", {31'b0, mem_we}, 32'h0);
    check("rst mem_addr", mem_addr, 32'h0);
    check("rst mem_wdata", mem_wdata, 32'h0);
    check("rst mem_be", {28'b0, mem_be}, 32'h0);
    check("rst Stall", {31'b0, Stall}, 32'h0);
    reset = 1'b0;

    // Stray acks while idle must not start anything; non-memory cycles never stall.
    ok = 1'b1;
    mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); #1;
      if (mem_req || Stall || ReadData !== 32'h0) ok = 1'b0;
    end
    mem_ack = 1'b0;
    check("idle_ack_ignored", {31'b0, ok}, 32'd1);
    @(negedge clk);

    for (int i = 0; i < 10; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Reset in the third REQ cycle of a load that is never acknowledged.
    MemRead = 1'b1; MemWrite = 1'b0; ByteOp = 1'b0; Addr = 32'h900; WriteData = 32'h0;
    ok = 1'b0;
    for (int c = 0, r = 0; c < 10 && !ok; c++) begin
      #1;
      mem_ack = 1'b0;
      if (mem_req) r++;
      if (r == 3) begin
        ok = 1'b1;
        reset = 1'b1; MemRead = 1'b0;
        #1;
        check("rstmid mem_req", {31'b0, mem_req}, 32'h0);
        check("rstmid Stall", {31'b0, Stall}, 32'h0);
        check("rstmid ReadData", ReadData, 32'h0);
        check("rstmid Fault", {31'b0, Fault}, 32'h0);
        check("rstmid mem_be", {28'b0, mem_be}, 32'h0);
      end else begin
        @(negedge clk);
      end
    end
    check("rstmid reached_req3", {31'b0, ok}, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    ok = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); #1;
      if (mem_req || Fault || Stall) ok = 1'b0;
    end
    check("rstmid no_done_after", {31'b0, ok}, 32'd1);
    @(negedge clk);
    run_vec(post_st, "post_rst_store");
    run_vec(post_ld, "post_rst_load");

    // Strobes held high across three instructions, ack in the first REQ cycle.
    MemRead = 1'b1; MemWrite = 1'b0; ByteOp = 1'b0; Addr = 32'hB04; mem_rdata = 32'h13579BDF;
    prev = 1'b0; rises = 0; req_hi = 0; done_cnt = 0; last_rise = -1; ok = 1'b1;
    for (int c = 0; c < 9; c++) begin
      #1;
      if (mem_req) req_hi++;
      if (mem_req && !prev) begin
        rises++;
        if (last_rise >= 0 && c - last_rise != 3) ok = 1'b0;
        last_rise = c;
      end
      if (!Stall) done_cnt++;
      mem_ack = mem_req;
      prev = mem_req;
      @(negedge clk);
    end
    MemRead = 1'b0; mem_ack = 1'b0;
    check("b2b req_rises", rises, 32'd3);
    check("b2b req_cycles", req_hi, 32'd3);
    check("b2b done_cycles", done_cnt, 32'd3);
    check("b2b spacing", {31'b0, ok}, 32'd1);
    check("b2b ReadData", ReadData, 32'h13579BDF);
    ok = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      if (mem_req || Stall) ok = 1'b0;
      @(negedge clk);
    end
    check("b2b quiet_after", {31'b0, ok}, 32'd1);
    check("scoreboard_empty", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multi-cycle load/store unit between the single-cycle ARM datapath and a handshaked data memory. It takes the datapath's memory-stage outputs (ALU result as address, store data, read/write strobes) and runs a req/ack bus transaction, handling byte and word accesses. It returns `ReadData` to the result mux and asserts `Stall` so that the PC and register file hold until the access completes. A bounded wait counter turns a missing acknowledge into a fault instead of a hang.

## Interface
- `TIMEOUT`, 15: cycles in REQ without `mem_ack` before the access aborts (1..255).
- `FAULT_DATA`, 32'hDEADBEEF: value returned on `ReadData` for an aborted load.

- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `MemRead`  in  1  load request from the control unit.
- `MemWrite`  in  1  store request from the control unit.
- `ByteOp`  in  1  1 = byte access (LDRB/STRB), 0 = word.
- `Addr`  in  32  byte address (ALUResult).
- `WriteData`  in  32  store data (register-file port 2).
- `ReadData`  out  32  load result to the result mux.
- `Stall`  out  1  hold PC/regfile writes while high.
- `Fault`  out  1  one-cycle pulse on timeout abort.
- `mem_req`  out  1  bus request.
- `mem_we`  out  1  bus write enable.
- `mem_addr`  out  32  word-aligned address ({Addr[31:2],2'b00}).
- `mem_wdata`  out  32  bus write data.
- `mem_be`  out  4  byte enables.
- `mem_rdata`  in  32  bus read data, valid with `mem_ack`.
- `mem_ack`  in  1  bus acknowledge, single-cycle.

## Operation
- The FSM has three states: IDLE, REQ and DONE.
- **IDLE**
  - If `MemRead|MemWrite`: `Stall`=1 combinationally; latch address, byte enables, write data and `we`; go to REQ.
  - Otherwise `Stall`=0 and the state stays IDLE.
- **REQ**
  - `mem_req`=1; all bus outputs come from registers and stay stable for the whole of REQ; `Stall`=1.
  - On `mem_ack`=1 at a rising edge: for a load, capture the formatted `mem_rdata` into `ReadData`; go to DONE.
  - Otherwise increment the wait counter. When the counter equals `TIMEOUT-1` without ack: go to DONE and pulse `Fault` during DONE. A load writes `FAULT_DATA` to `ReadData`; a store is dropped.
- **DONE**
  - `Stall`=0 and `mem_req`=0 for exactly one cycle, so the datapath commits the instruction.
  - Unconditionally go to IDLE. This prevents re-issuing the same instruction whose strobes are still asserted.
- Both `MemRead` and `MemWrite` high counts as a store; the read is ignored.
- **Word access:** `mem_be`=4'b1111, `mem_wdata`=`WriteData`; `Addr[1:0]` is ignored (forced alignment); a load returns `mem_rdata`.
- **Byte access, lane n = `Addr[1:0]`:**
  - `mem_be`=4'b0001<<n.
  - `mem_wdata`=`{4{WriteData[7:0]}}`.
  - A load returns `{24'b0, mem_rdata[8n+7:8n]}` (zero-extended).
- `mem_ack` outside REQ is ignored.
- The wait counter is 8 bits and clears when entering REQ.

## Timing
- **Reset values:** state=IDLE, `ReadData`=0, `Fault`=0, `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `mem_be`=0, wait counter=0. `Stall` follows IDLE decoding.
- Asserting `reset` mid-REQ drops `mem_req` immediately (asynchronous); the transaction is abandoned with no DONE cycle and no `Fault`.
- **Zero-wait access** (ack in the first REQ cycle): IDLE(Stall=1) → REQ(Stall=1) → DONE(Stall=0). The instruction occupies 3 cycles and `Stall` is high for 2.
- **k wait cycles:** `Stall` is high for 2+k cycles.
- **Timeout:** `mem_req` stays high exactly `TIMEOUT` cycles, then DONE with `Fault`=1 for 1 cycle.
- `ReadData` is valid from the DONE cycle and holds until the next completed load.
- Back-to-back memory instructions always pass through IDLE, giving a minimum 3-cycle spacing between `mem_req` rising edges.
- Non-memory instructions never stall.

## Test plan
- **Word load, zero wait:** `MemRead`=1, `Addr`=0x100, ack next cycle with `mem_rdata`=0x12345678 → `mem_addr`=0x100, `mem_be`=F, `Stall` high 2 cycles, `ReadData`=0x12345678 in DONE.
- **Byte store lane 3:** `MemWrite`=1, `ByteOp`=1, `Addr`=0x203, `WriteData`=0xAABBCCDD, ack after 2 waits → `mem_addr`=0x200, `mem_be`=4'b1000, `mem_wdata`=0xDDDDDDDD, `mem_we`=1, `Stall` high 4 cycles.
- **Byte load lane 1:** `Addr`=0x41, `mem_rdata`=0x11223344 → `ReadData`=0x00000033.
- **Timeout with `TIMEOUT`=15, load, ack never asserted** → `mem_req` high 15 cycles, `Fault` 1-cycle pulse, `ReadData`=0xDEADBEEF, then IDLE.
- **Reset asserted in the 3rd REQ cycle** → `mem_req`=0 and `Stall`=0 immediately (with strobes low), `ReadData`=0, state IDLE; a later access works normally.
- **Back-to-back loads with strobes held high across instructions** → exactly one `mem_req` per instruction, DONE separates them, no duplicate bus transaction.
